// File: rtl/picomips_acc_alu.sv
// picoMips accumulator datapath: one 8-bit signed accumulator updated from
// ACC and a selected operand by either a wrapping add or a Q.3 fixed-point multiply.

module picomips_mul8 (
  input  logic signed [7:0]  a_i,
  input  logic signed [7:0]  b_i,
  output logic signed [15:0] p_o
);

  // Both operands are signed, so the product is sign-extended to the full 16 bits.
  assign p_o = a_i * b_i;

endmodule

module picomips_acc_alu (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [7:0] Imm,
  input  logic [2:0] Func,
  input  logic       WE,
  input  logic       SelImm,
  input  logic       SelSW,
  input  logic       UseMul,
  input  logic       UseACC,
  input  logic [7:0] SW,
  input  logic [7:0] RegData,
  output logic [7:0] ACC
);

  logic        [7:0]  acc_q, acc_d;
  logic signed [7:0]  op_a, op_b;
  logic signed [15:0] prod;
  logic        [7:0]  sum;
  logic        [7:0]  result;

  // The opcode is visible here only for debug; the decoder drives the selects.
  // Product bits outside [10:3] are dropped by the fixed-point scaling.
  logic unused_bits;
  assign unused_bits = ^{Func, prod[15:11], prod[2:0]};

  always_comb begin
    if (SelImm)     op_b = Imm;
    else if (SelSW) op_b = SW;
    else            op_b = RegData;
  end

  assign op_a = UseACC ? acc_q : 8'sd0;
  assign sum  = op_a + op_b;

  picomips_mul8 u_mul (
    .a_i (op_a),
    .b_i (op_b),
    .p_o (prod)
  );

  // Arithmetic shift right by 3 of the signed product, wrapped to 8 bits.
  assign result = UseMul ? prod[10:3] : sum;
  assign acc_d  = WE ? result : acc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async clear sits in the sensitivity list.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) acc_q <= 8'h00;
    else         acc_q <= acc_d;
  end

  assign ACC = acc_q;

endmodule

// File: tb/tb_picomips_acc_alu.sv
// Self-checking bench for picomips_acc_alu: directed cases with literal
// expectations plus randomized operations compared every cycle against a model.

module tb_picomips_acc_alu;

  logic       Clock = 1'b0;
  logic       nReset;
  logic [7:0] Imm, SW, RegData, ACC;
  logic [2:0] Func;
  logic       WE, SelImm, SelSW, UseMul, UseACC;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] model_acc = 8'h00;
  bit chk_en = 1'b0;

  picomips_acc_alu dut (
    .Clock   (Clock),
    .nReset  (nReset),
    .Imm     (Imm),
    .Func    (Func),
    .WE      (WE),
    .SelImm  (SelImm),
    .SelSW   (SelSW),
    .UseMul  (UseMul),
    .UseACC  (UseACC),
    .SW      (SW),
    .RegData (RegData),
    .ACC     (ACC)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: ACC=%02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: signed integer arithmetic, floor division by 8 for the multiply.
  function automatic logic [7:0] model_next();
    int a, b, p, r;
    a = UseACC ? int'($signed(model_acc)) : 0;
    if (SelImm)     b = int'($signed(Imm));
    else if (SelSW) b = int'($signed(SW));
    else            b = int'($signed(RegData));
    if (UseMul) begin
      p = a * b;
      r = (p - (((p % 8) + 8) % 8)) / 8;
    end else begin
      r = a + b;
    end
    return r[7:0];
  endfunction

  always @(negedge Clock)
    if (chk_en) check("cycle", ACC, model_acc);

  // One rising edge; the model is advanced from the inputs held across it.
  task automatic step();
    @(posedge Clock);
    #1;
    if (!nReset)  model_acc = 8'h00;
    else if (WE)  model_acc = model_next();
  endtask

  task automatic drive(input bit si, input bit ss, input bit um, input bit ua, input bit we,
                       input logic [7:0] imm, input logic [7:0] sw, input logic [7:0] rd);
    SelImm = si; SelSW = ss; UseMul = um; UseACC = ua; WE = we;
    Imm = imm; SW = sw; RegData = rd;
  endtask

  task automatic op(input bit si, input bit ss, input bit um, input bit ua, input bit we,
                    input logic [7:0] imm, input logic [7:0] sw, input logic [7:0] rd,
                    input string name, input logic [7:0] exp);
    drive(si, ss, um, ua, we, imm, sw, rd);
    step();
    check(name, ACC, exp);
  endtask

  task automatic load(input logic [7:0] v);
    op(1, 0, 0, 0, 1, v, 8'h00, 8'h00, "load_imm", v);
  endtask

  initial begin
    nReset = 1'b0;
    Func = 3'd0;
    drive(0, 0, 0, 0, 1, 8'h33, 8'h44, 8'h55);
    #1 chk_en = 1'b1;
    step();
    check("reset_hold", ACC, 8'h00);
    #2 nReset = 1'b1;

    // Asynchronous clear between edges, then hold clear across a write edge.
    load(8'h55);
    #2 nReset = 1'b0;
    model_acc = 8'h00;
    #1 check("async_reset", ACC, 8'h00);
    op(1, 0, 0, 0, 1, 8'h66, 8'h00, 8'h00, "reset_blocks_we", 8'h00);
    #2 nReset = 1'b1;
    op(1, 0, 0, 0, 0, 8'h66, 8'h00, 8'h00, "reset_release_we0", 8'h00);

    op(0, 1, 0, 0, 1, 8'h00, 8'h40, 8'h00, "load_sw", 8'h40);
    op(0, 1, 0, 0, 0, 8'h00, 8'h11, 8'h00, "we0_hold", 8'h40);

    op(1, 0, 1, 1, 1, 8'h06, 8'h00, 8'h00, "mul_0p75", 8'h30);
    op(1, 0, 1, 1, 1, 8'hFC, 8'h00, 8'h00, "mul_neg0p5", 8'hE8);
    load(8'h05);
    op(1, 0, 1, 1, 1, 8'h04, 8'h00, 8'h00, "mul_trunc_pos", 8'h02);
    load(8'hFB);
    op(1, 0, 1, 1, 1, 8'h04, 8'h00, 8'h00, "mul_floor_neg", 8'hFD);
    op(1, 0, 1, 0, 1, 8'h7F, 8'h00, 8'h00, "mul_load_zero", 8'h00);

    load(8'h30);
    op(1, 0, 0, 1, 1, 8'h14, 8'h00, 8'h00, "addi_pos", 8'h44);
    op(1, 0, 0, 1, 1, 8'hEC, 8'h00, 8'h00, "addi_neg", 8'h30);
    load(8'h7F);
    op(1, 0, 0, 1, 1, 8'h02, 8'h00, 8'h00, "addi_wrap", 8'h81);

    load(8'h20);
    op(0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h10, "add_reg", 8'h30);
    op(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'hF0, "load_reg", 8'hF0);

    op(1, 1, 0, 0, 1, 8'h02, 8'h7F, 8'h00, "sel_priority", 8'h02);
    for (int f = 0; f < 8; f++) begin
      Func = 3'(f);
      op(1, 1, 0, 0, 1, 8'h02, 8'h7F, 8'h00, "func_ignored", 8'h02);
    end

    // Randomized operations with occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      Func = 3'($urandom_range(0, 7));
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0),
            8'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        nReset = 1'b0;
        model_acc = 8'h00;
      end else begin
        nReset = 1'b1;
      end
      step();
    end

    nReset = 1'b1;
    WE = 1'b0;
    step();
    @(negedge Clock);
    #1 chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/picomips_acc_alu.md
# picomips_acc_alu

Accumulator-based datapath for the picoMips processor. It holds the single 8-bit signed accumulator (ACC) and computes the next accumulator value from the current ACC and one selected operand. The operand is an immediate, the switch inputs, or register-file data. The result is an add or a fixed-point multiply. The instruction decoder drives all selects and the write enable; ACC drives the LEDs directly.

## Interface
- No parameters. Data width is fixed at 8 bits, two's complement.
- Clock: one clock; all state changes on the rising edge.
- nReset: asynchronous, active-low reset.
- Clock  in  1  system clock.
- nReset  in  1  clears ACC immediately when low.
- Imm  in  8  signed immediate, already sign-extended and scaled by the decoder.
- Func  in  3  opcode field, for visibility only.
  - Not decoded internally; behaviour depends only on the explicit selects.
- WE  in  1  accumulator write enable.
- SelImm  in  1  operand B = Imm.
- SelSW  in  1  operand B = SW, when SelImm = 0.
- UseMul  in  1  1 = multiply, 0 = add.
- UseACC  in  1  operand A = ACC when 1, else A = 0.
- SW  in  8  switch data, signed.
- RegData  in  8  register-file read data, signed.
- ACC  out  8  current accumulator value, signed.

## Operation
- Operand B is selected by priority mux:
  - SelImm = 1 → Imm.
  - SelImm = 0, SelSW = 1 → SW.
  - Otherwise → RegData.
- Operand A = UseACC ? ACC : 8'd0.
- Add path (UseMul = 0): R = (A + B) mod 256.
  - No saturation; carry and overflow are discarded.
- Multiply path (UseMul = 1):
  - P = A × B, a full 16-bit signed product, computed in a separate combinational signed 8×8 multiplier submodule.
  - R = P[10:3], i.e. an arithmetic shift right by 3 (Q·/8 fixed point), truncated to 8 bits.
  - Rounding is toward −∞; bits above P[10] are discarded (wrap).
  - Imm 0x06 = ×0.75, 0x04 = ×0.5, 0xFC = ×−0.5.
- Load forms (UseACC = 0):
  - Add path: ACC ← B (load SW, load register).
  - Multiply path: always writes 0.
- Accumulate forms (UseACC = 1): ADD, ADDI and MULI all use the pre-edge ACC value.
- Inputs not needed by the selected path are don't-care.
- Signals such as Func, SW or RegData have no effect when unselected.

## Timing
- R is purely combinational from the inputs and the current ACC.
- On a rising Clock with WE = 1: ACC ← R. ACC is visible immediately after the edge (latency 1 cycle from operand presentation).
- WE = 0: ACC holds its value indefinitely.
- nReset low: ACC = 0x00 asynchronously, regardless of Clock or WE.
  - Reset release is sampled normally; the first edge with nReset high and WE = 1 loads R.
  - Reset asserted mid-sequence discards any pending write.
- No handshake and no internal state other than ACC. There is no FSM.
- Every cycle is independent; back-to-back writes on consecutive edges chain correctly.

## Test plan
- Reset:
  - Load ACC = 0x55, then pulse nReset low between clock edges → ACC = 0x00 without waiting for a clock edge.
  - ACC stays 0x00 after nReset rises with WE = 0.
- Load SW:
  - SelImm=0, SelSW=1, UseACC=0, UseMul=0, SW=0x40, WE=1 → after the edge ACC = 0x40.
  - Repeat with WE=0 and SW=0x11 → ACC stays 0x40.
- Multiply:
  - ACC=0x40, SelImm=1, UseACC=1, UseMul=1, Imm=0x06 → ACC = 0x30 (64×0.75 = 48).
  - Then Imm=0xFC → ACC = 0xE8 (48×−0.5 = −24).
  - ACC=0x05, Imm=0x04 → ACC = 0x02 (2.5 truncates to 2).
  - ACC=0xFB, Imm=0x04 → ACC = 0xFD (−2.5 rounds toward −∞ to −3).
- Add immediate:
  - ACC=0x30, SelImm=1, UseACC=1, UseMul=0, Imm=0x14 → ACC = 0x44 (48+20 = 68).
  - Then Imm=0xEC → ACC = 0x30 (68−20 = 48).
  - Wrap: ACC=0x7F, Imm=0x02 → ACC = 0x81.
- Register paths:
  - SelImm=0, SelSW=0, RegData=0x10, UseACC=1, UseMul=0, ACC=0x20 → ACC = 0x30.
  - UseACC=0, RegData=0xF0 → ACC = 0xF0.
- Select priority:
  - SelImm=1 and SelSW=1, Imm=0x02, SW=0x7F, UseACC=0, UseMul=0 → ACC = 0x02.
  - Then toggle Func through all 8 values with the selects fixed → results unchanged.
